// File: rtl/quad_encoder_frontend_pkg.sv
// Shared definitions for the quadrature encoder front end: decoder state
// encoding, direction constants and the transition classifier.
package quad_encoder_frontend_pkg;

  typedef enum logic [1:0] {
    S00 = 2'b00,
    S01 = 2'b01,
    S11 = 2'b11,
    S10 = 2'b10
  } quad_state_t;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_CW,
    EV_CCW,
    EV_ILLEGAL
  } quad_event_t;

  localparam logic DIR_CW  = 1'b1;
  localparam logic DIR_CCW = 1'b0;
  localparam int   POS_W   = 10;

  // Clockwise successor in the Gray sequence S00 -> S01 -> S11 -> S10 -> S00.
  function automatic quad_state_t cw_next(input quad_state_t s);
    case (s)
      S00:     return S01;
      S01:     return S11;
      S11:     return S10;
      default: return S00;
    endcase
  endfunction

  function automatic quad_event_t classify(input quad_state_t cur, input quad_state_t nxt);
    if (nxt == cur)          return EV_NONE;
    if (nxt == cw_next(cur)) return EV_CW;
    if (cur == cw_next(nxt)) return EV_CCW;
    return EV_ILLEGAL;
  endfunction

endpackage

// File: rtl/quad_debounce_channel.sv
// One encoder channel: 2-flop synchronizer followed by an optional stability
// filter compiled in with QUAD_DEBOUNCE_EN; otherwise the filter is a wire.
module quad_debounce_channel #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic filt
);

  logic sync1;
  logic sync2;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

`ifdef QUAD_DEBOUNCE_EN
  logic [15:0] count;
  logic        filt_state;

  // Counts consecutive cycles of disagreement; any agreement restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count      <= 16'd0;
      filt_state <= 1'b0;
    end else if (sync2 == filt_state) begin
      count <= 16'd0;
    end else if (count == 16'(DEBOUNCE_CYCLES - 1)) begin
      count      <= 16'd0;
      filt_state <= sync2;
    end else begin
      count <= count + 16'd1;
    end
  end

  assign filt = filt_state;
`else
  // The filter length only matters when the filter exists.
  if (DEBOUNCE_CYCLES >= 0) begin : g_bypass
    assign filt = sync2;
  end
`endif

endmodule

// File: rtl/quad_encoder_frontend.sv
// Quadrature encoder front end: synchronize/filter A and B, decode steps and
// keep a saturating position. Debounce filter is enabled by QUAD_DEBOUNCE_EN.
module quad_encoder_frontend
  import quad_encoder_frontend_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int STEP_SIZE       = 4,
  parameter int POS_MIN         = 0,
  parameter int POS_MAX         = 576
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rota,
  input  logic             rotb,
  input  logic             pos_load,
  input  logic [POS_W-1:0] pos_load_value,
  output logic             step_valid,
  output logic             step_dir,
  output logic [POS_W-1:0] position,
  output logic             illegal
);

  localparam logic [POS_W:0] STEP_W = (POS_W + 1)'(STEP_SIZE);
  localparam logic [POS_W:0] MIN_W  = (POS_W + 1)'(POS_MIN);
  localparam logic [POS_W:0] MAX_W  = (POS_W + 1)'(POS_MAX);

  logic [1:0]   raw_ab;
  logic [1:0]   filt_ab;
  quad_state_t  state;
  quad_event_t  ev;
  logic [POS_W:0] pos_wide;
  logic [POS_W:0] pos_up;
  logic [POS_W:0] pos_down;
  logic [POS_W:0] load_wide;
  logic [POS_W:0] load_clamped;
  logic [POS_W:0] pos_next;

  assign raw_ab = {rota, rotb};

  for (genvar gi = 0; gi < 2; gi++) begin : g_chan
    quad_debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_chan (
      .clk  (clk),
      .reset(reset),
      .raw  (raw_ab[gi]),
      .filt (filt_ab[gi])
    );
  end

  // One bit of headroom keeps the increment from wrapping before the clamp.
  always_comb begin
    ev        = classify(state, quad_state_t'(filt_ab));
    pos_wide  = {1'b0, position};
    pos_up    = pos_wide + STEP_W;
    if (pos_up > MAX_W) pos_up = MAX_W;
    pos_down  = (pos_wide < MIN_W + STEP_W) ? MIN_W : pos_wide - STEP_W;
    load_wide = {1'b0, pos_load_value};
    if (load_wide < MIN_W)      load_clamped = MIN_W;
    else if (load_wide > MAX_W) load_clamped = MAX_W;
    else                        load_clamped = load_wide;
    pos_next = pos_wide;
    if (pos_load)            pos_next = load_clamped;
    else if (ev == EV_CW)    pos_next = pos_up;
    else if (ev == EV_CCW)   pos_next = pos_down;
  end

  // Decoder FSM; the state simply follows the filtered pair, even on illegal jumps.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= S00;
      step_valid <= 1'b0;
      step_dir   <= DIR_CCW;
      illegal    <= 1'b0;
      position   <= POS_W'(POS_MIN);
    end else begin
      state      <= quad_state_t'(filt_ab);
      step_valid <= (ev == EV_CW) || (ev == EV_CCW);
      illegal    <= (ev == EV_ILLEGAL);
      if (ev == EV_CW)       step_dir <= DIR_CW;
      else if (ev == EV_CCW) step_dir <= DIR_CCW;
      position   <= POS_W'(pos_next);
    end
  end

endmodule

// File: tb/tb_quad_encoder_frontend.sv
// Directed bench for quad_encoder_frontend with default parameters; the
// debounce glitch/hold steps apply only when QUAD_DEBOUNCE_EN is defined.
module tb_quad_encoder_frontend;

`ifdef QUAD_DEBOUNCE_EN
  localparam int LAT = 3 + 16;
`else
  localparam int LAT = 3;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       rota;
  logic       rotb;
  logic       pos_load;
  logic [9:0] pos_load_value;
  logic       step_valid;
  logic       step_dir;
  logic [9:0] position;
  logic       illegal;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  quad_encoder_frontend dut (
    .clk           (clk),
    .reset         (reset),
    .rota          (rota),
    .rotb          (rotb),
    .pos_load      (pos_load),
    .pos_load_value(pos_load_value),
    .step_valid    (step_valid),
    .step_dir      (step_dir),
    .position      (position),
    .illegal       (illegal)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Apply AB, run for hold cycles, then check pulse counts, latency, held dir and position.
  task automatic move(input logic a, input logic b, input int hold, input int exp_steps,
                      input int exp_ill, input logic exp_dir, input int exp_pos,
                      input string tag);
    int steps = 0;
    int ills  = 0;
    int first = -1;
    rota = a;
    rotb = b;
    for (int i = 1; i <= hold; i++) begin
      tick();
      if (step_valid === 1'b1) begin
        steps++;
        if (first < 0) first = i;
      end
      if (illegal === 1'b1) begin
        ills++;
        if (first < 0) first = i;
      end
    end
    chk({tag, " steps"}, steps, exp_steps);
    chk({tag, " illegal"}, ills, exp_ill);
    if (exp_steps + exp_ill > 0) chk({tag, " latency"}, first, LAT);
    chk({tag, " dir"}, step_dir, exp_dir);
    chk({tag, " position"}, position, exp_pos);
    $display("move %-14s AB=%b%b steps=%0d illegal=%0d first=%0d dir=%b pos=%0d",
             tag, a, b, steps, ills, first, step_dir, position);
  endtask

  task automatic load(input int value, input int exp_pos, input string tag);
    pos_load       = 1'b1;
    pos_load_value = 10'(value);
    tick();
    pos_load = 1'b0;
    chk({tag, " position"}, position, exp_pos);
    $display("load %-14s value=%0d pos=%0d", tag, value, position);
  endtask

  initial begin
    reset          = 1'b1;
    rota           = 1'b0;
    rotb           = 1'b0;
    pos_load       = 1'b0;
    pos_load_value = 10'd0;
    repeat (3) tick();
    chk("reset step_valid", step_valid, 0);
    chk("reset step_dir", step_dir, 0);
    chk("reset illegal", illegal, 0);
    chk("reset position", position, 0);
    reset = 1'b0;
    repeat (2) tick();

    // Full clockwise cycle from position 0.
    move(1'b0, 1'b1, 20, 1, 0, 1'b1, 4,  "cw_00_01");
    move(1'b1, 1'b1, 20, 1, 0, 1'b1, 8,  "cw_01_11");
    move(1'b1, 1'b0, 20, 1, 0, 1'b1, 12, "cw_11_10");
    move(1'b0, 1'b0, 20, 1, 0, 1'b1, 16, "cw_10_00");
    move(1'b1, 1'b0, 20, 1, 0, 1'b0, 12, "ccw_00_10");
    move(1'b0, 1'b0, 20, 1, 0, 1'b1, 16, "cw_10_00b");
    move(1'b0, 1'b0, 10, 0, 0, 1'b1, 16, "idle_hold");

    // Saturation at both ends.
    load(574, 574, "load_574");
    move(1'b0, 1'b1, 20, 1, 0, 1'b1, 576, "sat_up1");
    move(1'b1, 1'b1, 20, 1, 0, 1'b1, 576, "sat_up2");
    load(2, 2, "load_2");
    move(1'b0, 1'b1, 20, 1, 0, 1'b0, 0, "sat_down");
    move(1'b0, 1'b0, 20, 1, 0, 1'b0, 0, "sat_down2");

    // Two-bit jump, then a legal CW step from the new state.
    move(1'b1, 1'b1, 20, 0, 1, 1'b0, 0, "illegal_00_11");
    move(1'b1, 1'b0, 20, 1, 0, 1'b1, 4, "after_illegal");

    // Load coinciding with a CW step wins.
    rota = 1'b0;
    rotb = 1'b0;
    repeat (LAT - 1) tick();
    pos_load       = 1'b1;
    pos_load_value = 10'd300;
    tick();
    pos_load = 1'b0;
    chk("load_vs_step step_valid", step_valid, 1);
    chk("load_vs_step position", position, 300);
    tick();
    chk("load_vs_step hold", position, 300);
    $display("load load_vs_step   value=300 step_valid_seen=1 pos=%0d", position);
    load(900, 576, "load_900_clamp");

`ifdef QUAD_DEBOUNCE_EN
    move(1'b1, 1'b0, 10, 0, 0, 1'b1, 576, "db_glitch");
    move(1'b0, 1'b0, 30, 0, 0, 1'b1, 576, "db_glitch_end");
    move(1'b1, 1'b0, 40, 1, 0, 1'b0, 572, "db_hold");
    move(1'b0, 1'b0, 40, 1, 0, 1'b1, 576, "db_return");
`endif

    // Asynchronous reset in the middle of a transition.
    load(200, 200, "load_200");
    rota = 1'b0;
    rotb = 1'b1;
    tick();
    #2;
    reset = 1'b1;
    #1;
    chk("async_reset step_valid", step_valid, 0);
    chk("async_reset step_dir", step_dir, 0);
    chk("async_reset illegal", illegal, 0);
    chk("async_reset position", position, 0);
    $display("rst  mid_transition  pos=%0d dir=%b", position, step_dir);
    rota = 1'b0;
    rotb = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    move(1'b0, 1'b0, 20, 0, 0, 1'b0, 0, "post_rst_idle");
    move(1'b0, 1'b1, 20, 1, 0, 1'b1, 4, "post_rst_cw");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/quad_encoder_frontend.md
QUAD_ENCODER_FRONTEND -- requirements
Module: quad_encoder_frontend

Interface
REQ-001 The block SHALL have parameter DEBOUNCE_CYCLES, default 16, consecutive stable cycles required before a filtered channel changes (range 1..65535).
REQ-002 The block SHALL have parameter STEP_SIZE, default 4, position increment per valid transition.
REQ-003 The block SHALL have parameter POS_MIN, default 0, lower position bound.
REQ-004 The block SHALL have parameter POS_MAX, default 576, upper position bound.
REQ-005 The block SHALL have port clk, input, 1, system clock.
REQ-006 The block SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-007 The block SHALL have port rota, input, 1, raw encoder channel A, asynchronous to clk.
REQ-008 The block SHALL have port rotb, input, 1, raw encoder channel B, asynchronous to clk.
REQ-009 The block SHALL have port pos_load, input, 1, load position from pos_load_value this cycle.
REQ-010 The block SHALL have port pos_load_value, input, 10, position to load.
REQ-011 The block SHALL have port step_valid, output, 1, one-cycle pulse per valid quadrature transition.
REQ-012 The block SHALL have port step_dir, output, 1, direction qualifying step_valid: 1 = CW/increment, 0 = CCW/decrement.
REQ-013 The block SHALL have port position, output, 10, saturating accumulated position.
REQ-014 The block SHALL have port illegal, output, 1, one-cycle pulse when both filtered channels change in the same cycle.

Function
REQ-015 rota and rotb SHALL each pass through a 2-flop synchronizer before any other logic.
REQ-016 With debounce compiled in, each synchronized channel SHALL feed a counter; the filtered value updates only after the synchronized value differs from it for DEBOUNCE_CYCLES consecutive cycles; any return to the filtered value clears the counter.
REQ-017 The decoder SHALL be a 4-state FSM, S00/S01/S11/S10, state = {filtA, filtB}.
REQ-018 Transitions S00->S01->S11->S10->S00 SHALL be CW (step_valid=1, step_dir=1); the reverse sequence SHALL be CCW (step_dir=0).
REQ-019 A two-bit change, e.g. S00->S11, SHALL pulse illegal, produce no step, and move the FSM to the new state.
REQ-020 No change SHALL produce no pulse; step_dir SHALL hold its last value when step_valid=0.
REQ-021 step_valid/illegal SHALL be registered, asserting the cycle after the filtered-state change.
REQ-022 Latency, raw edge to step_valid: 3 cycles without debounce; 3+DEBOUNCE_CYCLES cycles with debounce.
REQ-023 On step_valid with step_dir=1, position SHALL become min(position+STEP_SIZE, POS_MAX), computed 11 bits wide, no wrap.
REQ-024 On step_valid with step_dir=0, position SHALL become max(position-STEP_SIZE, POS_MIN), no underflow wrap.
REQ-025 position SHALL update in the same cycle step_valid is asserted.
REQ-026 pos_load SHALL take priority over a simultaneous step; the loaded value SHALL be clamped to [POS_MIN, POS_MAX].

Reset
REQ-027 Reset SHALL clear synchronizers, debounce counters and filtered channels to 0, FSM to S00, step_valid=0, step_dir=0, illegal=0, position=POS_MIN.
REQ-028 Reset asserted mid-debounce or mid-transition SHALL discard the partial count; after release the first transition SHALL be judged from S00.

Configuration
REQ-029 Macro QUAD_DEBOUNCE_EN defined SHALL compile in the debounce filter of REQ-016.
REQ-030 With QUAD_DEBOUNCE_EN undefined, the filtered channel SHALL equal the synchronized channel, DEBOUNCE_CYCLES SHALL be ignored, and no counter logic SHALL exist.

Structure
REQ-031 A shared package SHALL hold the FSM state encoding constants (S00, S01, S11, S10) and the direction constants DIR_CW=1, DIR_CCW=0.
REQ-032 Sub-module quad_debounce_channel (synchronizer + filter, one per channel) SHALL be instantiated twice.

Verification
REQ-033 No debounce: drive AB 00->01->11->10->00, 20 cycles per phase, from position 0 -> 4 step_valid pulses, step_dir=1, position=16.
REQ-034 Debounce, DEBOUNCE_CYCLES=16: glitch rota high for 10 cycles -> no step_valid, position unchanged; hold rota high for 40 cycles -> exactly one pulse, 19 cycles after the edge.
REQ-035 Saturation: load 574, then 2 CW steps -> position 576 after both; from 2, 1 CCW step -> position 0.
REQ-036 Illegal: flip rota and rotb together 00->11 -> illegal pulses once, no step_valid, FSM=S11; next move to S10 -> CW step.
REQ-037 Simultaneous pos_load=1 (value 300) and a CW step -> position=300; pos_load_value 900 -> position=576.
REQ-038 Assert reset mid-debounce with position 200 -> all outputs reset immediately, position=0; no pulse after release until a full new transition.
